branch_seq: RTL and testbench
=============================

BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port clr_n, input, 1, reset: synchronous, active-low, sampled on rising clk.
REQ-003 SHALL have port start, input, 1, one-cycle pulse meaning the instruction in ir is decoded and ready for branch execution.
REQ-004 SHALL have port ir, input, 32, instruction word: opcode ir[31:27], Ra ir[26:23], C2 ir[22:19].
REQ-005 SHALL have port con, input, 1, condition result from the CON flip-flop; valid from the cycle after con_in is asserted.
REQ-006 SHALL have port c2_field, output, 4, registered copy of ir[22:19], feeding the CON flip-flop.
REQ-007 SHALL have port gra / rout, output, 1 each, select Ra from IR and drive it onto the bus.
REQ-008 SHALL have port con_in, output, 1, CON flip-flop load enable.
REQ-009 SHALL have ports pc_out, y_in, c_out, z_in, alu_add, zlo_out, pc_in, output, 1 each, datapath control strobes.
REQ-010 SHALL have port busy, output, 1, high from acceptance until done.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port taken, output, 1, one-cycle pulse coincident with done when the branch is taken.
REQ-013 SHALL have port illegal, output, 1, one-cycle pulse when start arrives with a non-branch opcode.
REQ-014 SHALL have port taken_cnt, output, 16, count of taken branches.

Function
REQ-015 SHALL implement the FSM states IDLE, T3, T4, T5, T6.
REQ-016 IDLE: on start with ir[31:27]==OP_BR, SHALL latch ir into ir_q, load c2_field from ir[22:19], and go to T3 next cycle.
REQ-017 IDLE: on start with any other opcode, SHALL pulse illegal the next cycle and remain in IDLE.
REQ-018 T3: SHALL assert gra, rout and con_in, then go to T4.
REQ-019 T4: SHALL assert pc_out and y_in, then go to T5.
REQ-020 T5: SHALL assert c_out, z_in and alu_add, then go to T6.
REQ-021 T6: SHALL assert zlo_out; pc_in SHALL equal con sampled in T6.
REQ-022 T6: SHALL assert done; taken SHALL equal con; the FSM SHALL return to IDLE.
REQ-023 All control outputs SHALL be registered Moore outputs. The only exception is pc_in and taken in T6, which are gated by con.
REQ-024 Latency SHALL be 5 cycles from start to done (accept cycle, then T3 through T6); busy SHALL be high in T3 through T6.
REQ-025 start SHALL be ignored while busy; no queuing, no error.
REQ-026 ir SHALL only be sampled in IDLE; ir changes while busy SHALL have no effect.
REQ-027 taken_cnt SHALL increment by 1 on each taken pulse and SHALL saturate at 16'hFFFF; it never wraps.
REQ-028 At most one control strobe group SHALL be active per cycle. pc_out and zlo_out SHALL never be high together.

Reset
REQ-029 When clr_n is low at a rising clk edge: state SHALL be IDLE, and all 1-bit outputs, c2_field, ir_q and taken_cnt SHALL be 0.
REQ-030 Reset SHALL override everything in any state. Reset mid-branch SHALL abort with no pc_in and no done.
REQ-031 A start coincident with reset SHALL be discarded.

Structure
REQ-032 A shared package (cpu_pkg) SHALL hold OP_BR = 5'b10010, the IR field bit positions, and the state enumeration.
REQ-033 The saturating 16-bit counter SHALL be a sub-module, sat_counter16, with inputs clk, clr_n, inc and output count.
REQ-034 The block SHALL be a single clock domain with no latches and no combinational path from con to any output other than pc_in and taken.

Verification
REQ-035 Case taken: clr_n=0 for 2 cycles, then start with ir=32'h9000_0000 (brzr R0), con=1 in T6 -> con_in in cycle 2, pc_in=1 and done=1 and taken=1 in cycle 5, taken_cnt=1.
REQ-036 Case not taken: start with ir=32'h9088_0000 (c2_field=4'b0001), con=0 -> c2_field=1, pc_in=0, done=1, taken=0, taken_cnt unchanged.
REQ-037 Case non-branch: start with ir=32'h0800_0000 (opcode 00001) -> illegal pulse, busy stays 0, no strobes.
REQ-038 Case reset/start overlap: start again in T4, then clr_n=0 in T5 -> second start ignored, pc_in never asserted, state IDLE, all outputs 0.
REQ-039 Case saturation: force 65,536 taken branches -> taken_cnt holds 16'hFFFF and does not wrap to 0.
REQ-040 Case strobe exclusivity: a bench assertion SHALL check REQ-028 in every cycle of every test.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch sequencer.
// Contents: branch opcode, instruction-register field positions and the
// branch FSM state enumeration.
package cpu_pkg;

    localparam logic [4:0] OP_BR = 5'b10010;

    // Instruction-register field positions
    localparam int unsigned OpMsb = 31;
    localparam int unsigned OpLsb = 27;
    localparam int unsigned RaMsb = 26;
    localparam int unsigned RaLsb = 23;
    localparam int unsigned C2Msb = 22;
    localparam int unsigned C2Lsb = 19;

    typedef enum logic [2:0] {
        StIdle,
        StT3,
        StT4,
        StT5,
        StT6
    } state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that saturates at 16'hFFFF instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   clr_n - synchronous active-low clear
//   inc   - count enable, one increment per cycle while high
//   count - current count
module sat_counter16 (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_seq.sv
// Control sequencer for conditional branch execution (T3..T6 micro-steps).
// Ports:
//   clk, clr_n           - clock and synchronous active-low reset
//   start, ir            - decoded-instruction handshake and instruction word
//   con                  - CON flip-flop result, consumed in T6
//   c2_field             - registered C2 field feeding the CON flip-flop
//   gra, rout, con_in    - T3 strobes (select Ra, drive bus, load CON)
//   pc_out, y_in         - T4 strobes
//   c_out, z_in, alu_add - T5 strobes
//   zlo_out, pc_in       - T6 strobes (pc_in gated by con)
//   busy, done, taken    - status; done/taken pulse in T6
//   illegal              - pulse after start with a non-branch opcode
//   taken_cnt            - saturating count of taken branches
module branch_seq
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        con,
    output logic [3:0]  c2_field,
    output logic        gra,
    output logic        rout,
    output logic        con_in,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        z_in,
    output logic        alu_add,
    output logic        zlo_out,
    output logic        pc_in,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        illegal,
    output logic [15:0] taken_cnt
);

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    logic        accept, bad_op;
    logic        t3_q, t4_q, t5_q, t6_q;
    logic        busy_q, illegal_q;

    // State register
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start is only looked at in IDLE, so it is ignored while busy
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        bad_op  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (ir[OpMsb:OpLsb] == OP_BR) begin
                        accept  = 1'b1;
                        state_d = StT3;
                    end else begin
                        bad_op = 1'b1;
                    end
                end
            end
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = StT6;
            StT6:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output registers decoded from the next state so each strobe is a flop
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ir_q      <= '0;
            t3_q      <= 1'b0;
            t4_q      <= 1'b0;
            t5_q      <= 1'b0;
            t6_q      <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                ir_q <= ir;
            end
            t3_q      <= (state_d == StT3);
            t4_q      <= (state_d == StT4);
            t5_q      <= (state_d == StT5);
            t6_q      <= (state_d == StT6);
            busy_q    <= (state_d != StIdle);
            illegal_q <= bad_op;
        end
    end

    assign c2_field = ir_q[C2Msb:C2Lsb];
    assign gra      = t3_q;
    assign rout     = t3_q;
    assign con_in   = t3_q;
    assign pc_out   = t4_q;
    assign y_in     = t4_q;
    assign c_out    = t5_q;
    assign z_in     = t5_q;
    assign alu_add  = t5_q;
    assign zlo_out  = t6_q;
    assign done     = t6_q;
    assign busy     = busy_q;
    assign illegal  = illegal_q;

    // The only paths from con to outputs
    assign pc_in = t6_q & con;
    assign taken = t6_q & con;

    sat_counter16 u_taken_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (taken),
        .count (taken_cnt)
    );

    // Opcode and Ra are held for the datapath but not decoded further here
    logic unused_ir_q;
    assign unused_ir_q = ^{ir_q[OpMsb:OpLsb], ir_q[RaMsb:RaLsb], ir_q[C2Lsb-1:0]};

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: per-cycle strobe checks from the driver,
// a scoreboard of expected completions checked when done/illegal appear.
module tb_branch_seq;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n, start, con;
    logic [31:0] ir;
    logic [3:0]  c2_field;
    logic        gra, rout, con_in, pc_out, y_in, c_out, z_in, alu_add;
    logic        zlo_out, pc_in, busy, done, taken, illegal;
    logic [15:0] taken_cnt;

    always #5 clk = ~clk;

    branch_seq dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .ir        (ir),
        .con       (con),
        .c2_field  (c2_field),
        .gra       (gra),
        .rout      (rout),
        .con_in    (con_in),
        .pc_out    (pc_out),
        .y_in      (y_in),
        .c_out     (c_out),
        .z_in      (z_in),
        .alu_add   (alu_add),
        .zlo_out   (zlo_out),
        .pc_in     (pc_in),
        .busy      (busy),
        .done      (done),
        .taken     (taken),
        .illegal   (illegal),
        .taken_cnt (taken_cnt)
    );

    typedef struct packed {
        logic       is_illegal;
        logic       tk;
        logic [3:0] c2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] model_cnt;

    // {gra,rout,con_in,pc_out,y_in,c_out,z_in,alu_add,zlo_out,pc_in,busy,done,taken,illegal}
    logic [13:0] strb;
    assign strb = {gra, rout, con_in, pc_out, y_in, c_out, z_in, alu_add,
                   zlo_out, pc_in, busy, done, taken, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [13:0] phase_vec(input int ph, input logic c);
        logic [13:0] v;
        v = '0;
        case (ph)
            1: begin v[13] = 1'b1; v[12] = 1'b1; v[11] = 1'b1; v[3] = 1'b1; end
            2: begin v[10] = 1'b1; v[9] = 1'b1; v[3] = 1'b1; end
            3: begin v[8] = 1'b1; v[7] = 1'b1; v[6] = 1'b1; v[3] = 1'b1; end
            4: begin v[5] = 1'b1; v[4] = c; v[3] = 1'b1; v[2] = 1'b1; v[1] = c; end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Scoreboard consumer plus strobe-exclusivity assertion, every cycle
    logic [3:0] grp;
    always @(negedge clk) begin
        grp = {gra | rout | con_in, pc_out | y_in, c_out | z_in | alu_add, zlo_out | pc_in};
        strobe_excl: assert ($onehot0(grp) && !(pc_out && zlo_out))
            else $error("FAIL strobe_excl: groups=%b pc_out=%b zlo_out=%b", grp, pc_out, zlo_out);
        if (clr_n && (done || illegal)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_eq("sb_illegal", {31'd0, illegal}, {31'd0, sb_e.is_illegal});
                if (!sb_e.is_illegal) begin
                    check_eq("sb_taken", {31'd0, taken}, {31'd0, sb_e.tk});
                    check_eq("sb_pc_in", {31'd0, pc_in}, {31'd0, sb_e.tk});
                    check_eq("sb_c2", {28'd0, c2_field}, {28'd0, sb_e.c2});
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] ir_v, input logic c, input bit poke);
        bit is_br;
        is_br = (ir_v[31:27] == OP_BR);
        @(posedge clk); #1;
        start = 1'b1;
        ir    = ir_v;
        con   = c;
        if (is_br) begin
            sb_q.push_back('{is_illegal: 1'b0, tk: c, c2: ir_v[22:19]});
            if (c && (model_cnt != 16'hFFFF)) model_cnt = model_cnt + 16'd1;
        end else begin
            sb_q.push_back('{is_illegal: 1'b1, tk: 1'b0, c2: 4'd0});
        end
        @(posedge clk); #1;
        start = 1'b0;
        ir    = 32'h0878_0000;  // non-branch word with a different C2, must be ignored
        if (is_br) begin
            for (int ph = 1; ph <= 4; ph++) begin
                @(negedge clk);
                check_eq($sformatf("phase%0d", ph), {18'd0, strb}, {18'd0, phase_vec(ph, c)});
                if (poke && ph == 2) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            check_eq("post_idle", {18'd0, strb}, 32'd0);
            check_eq("c2_hold", {28'd0, c2_field}, {28'd0, ir_v[22:19]});
            check_eq("taken_cnt", {16'd0, taken_cnt}, {16'd0, model_cnt});
        end else begin
            @(negedge clk);
            check_eq("illegal_pulse", {18'd0, strb}, 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("illegal_after", {18'd0, strb}, 32'd0);
        end
    endtask

    logic [31:0] r;
    logic [4:0]  op;

    initial begin
        clr_n = 1'b0; start = 1'b0; ir = '0; con = 1'b0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_strb", {18'd0, strb}, 32'd0);
        check_eq("reset_c2", {28'd0, c2_field}, 32'd0);
        check_eq("reset_cnt", {16'd0, taken_cnt}, 32'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        run_op(32'h9000_0000, 1'b1, 1'b0);  // brzr R0, taken
        run_op(32'h9088_0000, 1'b0, 1'b0);  // not taken, c2=1
        run_op(32'h0800_0000, 1'b0, 1'b0);  // non-branch
        run_op(32'h9088_0000, 1'b1, 1'b1);  // taken, start poked in T4

        for (int i = 0; i < 4; i++) begin
            r = $urandom();
            run_op({OP_BR, r[26:0]}, r[31], r[30]);
            r  = $urandom();
            op = r[31:27];
            if (op == OP_BR) op = op ^ 5'b00001;
            run_op({op, r[26:0]}, r[0], 1'b0);
        end

        // Reset abort: start, re-start in T4, reset sampled at end of T5
        @(posedge clk); #1;
        start = 1'b1; ir = 32'h9000_0000; con = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        model_cnt = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("abort_idle%0d", k), {18'd0, strb}, 32'd0);
        end
        check_eq("abort_cnt", {16'd0, taken_cnt}, 32'd0);
        check_eq("abort_c2", {28'd0, c2_field}, 32'd0);

        // Start coincident with reset is discarded
        @(posedge clk); #1;
        clr_n = 1'b0; start = 1'b1; ir = 32'h9000_0000;
        @(posedge clk); #1;
        clr_n = 1'b1; start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq($sformatf("rst_start%0d", k), {18'd0, strb}, 32'd0);
        end

        // Saturation: preload near the top, then cross 16'hFFFF with real branches
        @(negedge clk);
        force dut.u_taken_cnt.count_q = 16'hFFFB;
        @(posedge clk); #1;
        release dut.u_taken_cnt.count_q;
        model_cnt = 16'hFFFB;
        @(negedge clk);
        check_eq("preload_cnt", {16'd0, taken_cnt}, {16'd0, model_cnt});
        repeat (7) run_op(32'h9000_0000, 1'b1, 1'b0);
        check_eq("sat_final", {16'd0, taken_cnt}, 32'h0000_FFFF);

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
